servo_pwm_multi: RTL and testbench



---
 rtl/motor_pkg.sv | 18 +
 rtl/servo_chan.sv | 58 +++++
 rtl/servo_pwm_multi.sv | 87 ++++++++
 tb/tb_servo_pwm_multi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared default constants and helpers for the servo motor drivers.
package motor_pkg;

  localparam int PERIOD_50M   = 1_000_000;
  localparam int SERVO_MIN_W  = 17_500;
  localparam int SERVO_MAX_W  = 57_500;
  localparam int SERVO_INIT_W = 37_500;
  localparam int SERVO_STEP   = 500;

  function automatic logic [31:0] clamp(input logic [31:0] value,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: target/current width registers, frame-boundary update and output compare.
// Defining SERVO_PWM_SLEW_EN limits each boundary update to STEP clocks.
module servo_chan
  import motor_pkg::*;
#(
  parameter int CW     = 21,
  parameter int MIN_W  = SERVO_MIN_W,
  parameter int MAX_W  = SERVO_MAX_W,
  parameter int INIT_W = SERVO_INIT_W
`ifdef SERVO_PWM_SLEW_EN
  ,
  parameter int STEP   = SERVO_STEP
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] count,
  input  logic          boundary,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_width,
  output logic          power,
  output logic          busy
);

  localparam logic [CW-1:0] INIT_V = CW'(INIT_W);

  logic [CW-1:0] tgt_w;
  logic [CW-1:0] cur_w;
  logic [CW-1:0] next_w;

  always_comb begin
    next_w = tgt_w;
`ifdef SERVO_PWM_SLEW_EN
    // Differences are taken in the safe direction only, so the step saturates at tgt_w.
    if (tgt_w > cur_w) begin
      if ((tgt_w - cur_w) > CW'(STEP)) next_w = cur_w + CW'(STEP);
    end else if ((cur_w - tgt_w) > CW'(STEP)) begin
      next_w = cur_w - CW'(STEP);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_w <= INIT_V;
      cur_w <= INIT_V;
      power <= 1'b0;
    end else begin
      if (wr_en) tgt_w <= CW'(clamp(32'(wr_width), 32'(MIN_W), 32'(MAX_W)));
      if (boundary) cur_w <= next_w;
      power <= enable && (count < cur_w);
    end
  end

  assign busy = (cur_w != tgt_w);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, write port and NCH servo_chan instances.
// Optional slew limiting of width changes is enabled with SERVO_PWM_SLEW_EN.
module servo_pwm_multi
  import motor_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CW     = 21,
  parameter int PERIOD = PERIOD_50M,
  parameter int MIN_W  = SERVO_MIN_W,
  parameter int MAX_W  = SERVO_MAX_W,
  parameter int INIT_W = SERVO_INIT_W,
  parameter int STEP   = SERVO_STEP
) (
  input  logic                                  m_clock,
  input  logic                                  p_reset,
  input  logic                                  enable,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [CW-1:0]                         wr_width,
  output logic [NCH-1:0]                        power,
  output logic [NCH-1:0]                        busy,
  output logic                                  frame_start
);

  localparam int            CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  if (NCH < 1 || NCH > 16 || CW > 32 || (longint'(PERIOD - 1) >> CW) != 0 ||
      MIN_W < 1 || MAX_W >= PERIOD || INIT_W < MIN_W || INIT_W > MAX_W || STEP < 1)
  begin : g_bad_params
    $error("servo_pwm_multi: inconsistent parameter set");
  end

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ready_arm;
  logic          boundary;
  logic          accept;

  always_comb begin
    count_next = '0;
    if (enable && (count != LAST)) count_next = count + CW'(1);
  end

  assign boundary = enable && (count == LAST);
  assign accept   = wr_valid && wr_ready;

  // wr_ready looks one cycle ahead so it is already low during the boundary cycle.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      count       <= '0;
      ready_arm   <= 1'b0;
      wr_ready    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      count       <= count_next;
      ready_arm   <= 1'b1;
      wr_ready    <= ready_arm && (count_next != LAST);
      frame_start <= enable && (count == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    servo_chan #(
      .CW     (CW),
      .MIN_W  (MIN_W),
      .MAX_W  (MAX_W),
      .INIT_W (INIT_W)
`ifdef SERVO_PWM_SLEW_EN
      ,
      .STEP   (STEP)
`endif
    ) u_chan (
      .clk      (m_clock),
      .reset    (p_reset),
      .enable   (enable),
      .count    (count),
      .boundary (boundary),
      .wr_en    (accept && (wr_ch == CHW'(i))),
      .wr_width (wr_width),
      .power    (power[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: table of width writes scored frame by frame,
// plus sequences for boundary-held writes, enable drop and mid-frame reset.
module tb_servo_pwm_multi;

  localparam int NCH    = 2;
  localparam int CW     = 21;
  localparam int PERIOD = 100;
  localparam int MIN_W  = 10;
  localparam int MAX_W  = 60;
  localparam int INIT_W = 30;
  localparam int STEP   = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [0:0]     wr_ch = 1'b0;
  logic [CW-1:0]  wr_width = '0;
  logic [NCH-1:0] power;
  logic [NCH-1:0] busy;
  logic           frame_start;

  servo_pwm_multi #(
    .NCH(NCH), .CW(CW), .PERIOD(PERIOD), .MIN_W(MIN_W),
    .MAX_W(MAX_W), .INIT_W(INIT_W), .STEP(STEP)
  ) dut (
    .m_clock     (clock),
    .p_reset     (reset),
    .enable      (enable),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_width    (wr_width),
    .power       (power),
    .busy        (busy),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct { int ch; int width; int exp_w; } vec_t;
  typedef struct { int w0; int w1; } exp_t;

  exp_t sb[$];
  int   m_cur[NCH];
  int   m_tgt[NCH];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   pend_active = 1'b0;
  bit   acc_done = 1'b0;
  int   pend_ch, pend_width, pend_exp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input int ch, input int width, input int expw);
    pend_active = 1'b1;
    pend_ch     = ch;
    pend_width  = width;
    pend_exp    = expw;
  endtask

  // Holds wr_valid until a cycle with wr_ready, then updates the target model.
  task automatic drive_write_step();
    if (acc_done) begin
      wr_valid = 1'b0;
      acc_done = 1'b0;
    end
    if (pend_active) begin
      wr_valid = 1'b1;
      wr_ch    = 1'(pend_ch);
      wr_width = CW'(pend_width);
      if (wr_ready === 1'b1) begin
        m_tgt[pend_ch] = pend_exp;
        pend_active    = 1'b0;
        acc_done       = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = INIT_W;
      m_tgt[i] = INIT_W;
    end
  endtask

  task automatic model_boundary();
    for (int i = 0; i < NCH; i++) begin
`ifdef SERVO_PWM_SLEW_EN
      if (m_tgt[i] > m_cur[i])
        m_cur[i] = m_cur[i] + ((m_tgt[i] - m_cur[i] > STEP) ? STEP : (m_tgt[i] - m_cur[i]));
      else
        m_cur[i] = m_cur[i] - ((m_cur[i] - m_tgt[i] > STEP) ? STEP : (m_cur[i] - m_tgt[i]));
`else
      m_cur[i] = m_tgt[i];
`endif
    end
  endtask

  task automatic check_busy();
    int e = 0;
    for (int i = 0; i < NCH; i++)
      if (m_cur[i] != m_tgt[i]) e = e | (1 << i);
    checkOutput("busy", busy, e);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 3 * PERIOD) begin
      drive_write_step();
      tick();
      n++;
    end
    if (frame_start !== 1'b1) checkOutput("frame_start timeout", frame_start, 1);
  endtask

  // Called with frame_start visible; scores one full frame and leaves at the next frame_start.
  task automatic measure_frame(input int wr_at, input int ch, input int width, input int expw);
    exp_t e;
    int   cnt[NCH];
    bit   contig[NCH];
    e.w0 = m_cur[0];
    e.w1 = m_cur[1];
    sb.push_back(e);
    for (int i = 0; i < NCH; i++) begin
      cnt[i]    = 0;
      contig[i] = 1'b1;
    end
    for (int k = 0; k < PERIOD; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (power[i] === 1'b1) begin
          if (cnt[i] != k) contig[i] = 1'b0;
          cnt[i]++;
        end
      end
      checkOutput("frame_start", frame_start, (k == 0) ? 1 : 0);
      check_busy();
      if (k >= 1) checkOutput("wr_ready", wr_ready, (k != PERIOD - 2) ? 1 : 0);
      if (k == wr_at) applyStimulus(ch, width, expw);
      drive_write_step();
      if (k == PERIOD - 2) model_boundary();
      tick();
    end
    e = sb.pop_front();
    checkOutput("ch0 width", cnt[0], e.w0);
    checkOutput("ch1 width", cnt[1], e.w1);
    checkOutput("ch0 glitch-free", contig[0], 1);
    checkOutput("ch1 glitch-free", contig[1], 1);
  endtask

  task automatic settle();
    int n = 0;
    while ((m_cur[0] != m_tgt[0] || m_cur[1] != m_tgt[1]) && n < 20) begin
      measure_frame(-1, 0, 0, 0);
      n++;
    end
    measure_frame(-1, 0, 0, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{0, 45, 45};
    vecs[1] = '{1, 5, 10};
    vecs[2] = '{1, 200, 60};
    vecs[3] = '{0, 9, 10};
    vecs[4] = '{0, 0, 10};
    vecs[5] = '{0, 60, 60};
    vecs[6] = '{1, 11, 11};
    vecs[7] = '{1, 2097151, 60};

    model_reset();
    tick();
    tick();
    checkOutput("reset power", power, 0);
    checkOutput("reset frame_start", frame_start, 0);
    checkOutput("reset wr_ready", wr_ready, 0);
    checkOutput("reset busy", busy, 0);
    reset = 1'b0;
    tick();
    checkOutput("wr_ready cycle after reset", wr_ready, 0);
    tick();
    checkOutput("wr_ready armed", wr_ready, 1);
    checkOutput("idle power", power, 0);

    enable = 1'b1;
    wait_fs();
    measure_frame(-1, 0, 0, 0);
    measure_frame(-1, 0, 0, 0);

    // Enable dropped at count 20 with a write pending for ch1.
    for (int k = 0; k < 20; k++) begin
      checkOutput("power before drop", power, 3);
      check_busy();
      if (k == 5) applyStimulus(1, 50, 50);
      if (k == 19) enable = 1'b0;
      drive_write_step();
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("power after drop", power, 0);
      checkOutput("frame_start while disabled", frame_start, 0);
      check_busy();
      drive_write_step();
      tick();
    end
    enable = 1'b1;
    tick();
    checkOutput("frame_start on re-enable", frame_start, 1);
    measure_frame(-1, 0, 0, 0);
    settle();

    // Write raised in the boundary cycle and held until accepted.
    measure_frame(PERIOD - 2, 0, 20, 20);
    settle();

    for (int v = 0; v < 8; v++) begin
      measure_frame(40, vecs[v].ch, vecs[v].width, vecs[v].exp_w);
      settle();
    end

    // Reset at count 50 with ch0 changing and a concurrent write to ch1.
    wait_fs();
    for (int k = 0; k < 49; k++) begin
      check_busy();
      if (k == 5) applyStimulus(0, 10, 10);
      drive_write_step();
      tick();
    end
    checkOutput("busy before reset", busy, 1);
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_ch    = 1'b1;
    wr_width = CW'(40);
    tick();
    reset       = 1'b0;
    wr_valid    = 1'b0;
    pend_active = 1'b0;
    acc_done    = 1'b0;
    model_reset();
    checkOutput("mid-frame reset power", power, 0);
    checkOutput("mid-frame reset busy", busy, 0);
    checkOutput("mid-frame reset wr_ready", wr_ready, 0);
    checkOutput("mid-frame reset frame_start", frame_start, 0);
    tick();
    checkOutput("wr_ready second cycle after reset", wr_ready, 0);
    checkOutput("frame_start after reset", frame_start, 1);
    measure_frame(-1, 0, 0, 0);
    measure_frame(-1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
